// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - loadable instruction RAM for the LEGv8 fetch stage with zero-clear and stream load port
module imem_loadable #(
  parameter int N      = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic              stall,
  output logic [N-1:0]      q,
  output logic              q_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [N-1:0]      load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [N-1:0]      mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [N-1:0]      mem_wd;
  logic              beat;
  logic              beat_end;

  // Fetch is only served in RUN; everything else reports busy to the pipeline.
  assign busy       = (state != S_RUN);
  assign load_ready = (state == S_LOAD);
  assign beat       = load_ready && load_valid;
  // A load ends on an explicit last word or when the top word is written; it never wraps.
  assign beat_end   = beat && (load_last || (wr_ptr == LAST_ADDR));

  // Single write port: zeroes during CLEAR, stream words during LOAD. Reads only happen in RUN,
  // so a write and a read can never coincide.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_ptr;
    mem_wd = '0;
    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
        mem_wd = '0;
      end
      S_LOAD: begin
        mem_we = load_valid;
        mem_wa = wr_ptr;
        mem_wd = load_data;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // RAM array write; the array itself is not reset, CLEAR zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Control FSM with registered fetch data and load status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      load_done  <= 1'b0;
      load_count <= '0;
      load_ovf   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          q_valid <= 1'b0;
          clr_ptr <= clr_ptr + ONE_ADDR;
          if (clr_ptr == LAST_ADDR) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (load_start) begin
            // A same-cycle fetch is dropped so the load owns the port from the next cycle.
            state    <= S_LOAD;
            wr_ptr   <= '0;
            load_ovf <= 1'b0;
            q_valid  <= 1'b0;
          end else if (!stall) begin
            if (rd_en) begin
              q <= mem[addr];
            end
            q_valid <= rd_en;
          end
        end
        S_LOAD: begin
          q_valid <= 1'b0;
          if (beat) begin
            if (beat_end) begin
              state      <= S_RUN;
              load_done  <= 1'b1;
              load_count <= {1'b0, wr_ptr} + {{ADDR_W{1'b0}}, 1'b1};
              if (!load_last) begin
                load_ovf <= 1'b1;
              end
            end else begin
              wr_ptr <= wr_ptr + ONE_ADDR;
            end
          end
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule
